seven_seg_display: RTL and testbench
====================================

Name: seven_seg_display

Overview:
- Consumes the four BCD digit buses (min_ten, min_one, sec_ten, sec_one) produced by the stopwatch counter.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Snapshots the digits once per scan frame so the display never tears mid-frame.
- Blinks the selected digit pair while adjust mode is active; sits between the counter and the board pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (min 2).
- BLINK_DIV, 25000000, clk cycles per blink half-period (min 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sec_one  input  4  seconds ones digit, BCD
- sec_ten  input  4  seconds tens digit, BCD
- min_one  input  4  minutes ones digit, BCD
- min_ten  input  4  minutes tens digit, BCD
- adj  input  1  adjust mode; enables blinking
- sel  input  1  blink target: 1 = seconds pair, 0 = minutes pair
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low; an[0] = sec_one ... an[3] = min_ten

Behaviour:
- Reset: applies only on a clk edge with rst=1.
  - State: refresh_cnt=0, idx=0, blink_cnt=0, blink_vis=1, snapshot digits=0.
  - Outputs: an=4'b1111, seg=7'h7F, dp=1.
  - Reset mid-frame aborts the frame; the scan restarts at idx 0 showing snapshot 0.
- Refresh counter: counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and idx increments 0→1→2→3→0.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- Snapshot: on the cycle refresh_cnt is terminal and idx==3, all four inputs are latched.
  - The new values are first shown in the idx 0 slot.
  - Input changes at any other time are invisible until the next frame boundary.
- Blink counter: free-runs 0..BLINK_DIV-1 regardless of adj; blink_vis toggles at terminal count.
- Refresh and blink terminal counts in the same cycle are handled independently.
- Outputs: registered, one-cycle latency from idx/snapshot/adj/sel/blink_vis.
  - an = one-hot-low of idx: idx0→1110, 1→1101, 2→1011, 3→0111.
  - dp = 0 only when idx==2 (separator after minutes), else 1.
  - seg decode (active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Values 10–15 → 7F (blank).
- Blink blanking: if adj=1 and blink_vis=0, seg=7F (dp=1) for the selected pair.
  - sel=1 blanks idx 0,1; sel=0 blanks idx 2,3.
  - an keeps scanning while blanked.
  - adj and sel are sampled live each cycle, not snapshotted.
- No combinational path from inputs to outputs.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
1. Reset: hold rst=1 for 3 cycles with arbitrary inputs -> an=1111, seg=7F, dp=1 throughout; 1 cycle after release, an=1110, seg=40.
2. Scan with adj=0, inputs 1,2,3,4 (min_ten..sec_one) from reset:
   - First frame shows 0s (seg=40 in all slots).
   - Second frame: an=1110/seg=19, then 1101/seg=30, then 1011/seg=24/dp=0, then 0111/seg=79.
   - Each slot lasts 4 cycles.
3. Decode sweep: drive sec_one through 0..15 across frames -> slot 0 seg matches the table; 10–15 give 7F.
4. No tearing: change inputs from 1234 to 5678 while idx==1 -> the rest of that frame still shows 1,2; the next frame shows 5,6,7,8.
5. Blink: adj=1, sel=1, inputs 1234 -> idx0/1 seg=7F during each 16-cycle blink_vis=0 window and show 4,3 otherwise; idx2/3 are never blanked.
   - Switching to sel=0 moves blanking to idx2/3 within 1 cycle.
   - adj=0 stops all blanking within 1 cycle.
6. Reset mid-frame: assert rst at idx==2 with snapshot 1234 -> next edge an=1111, seg=7F; after release the scan restarts at an=1110 with seg=40.

Source files
------------

// File: rtl/seven_seg_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_display_if
// Description : Bundle of the BCD digit inputs, adjust/blink controls and the
//               active-low display pin outputs exchanged between the
//               stopwatch side (master) and the display driver (slave).
//               Signals:
//                 sec_one/sec_ten/min_one/min_ten : BCD digits to display
//                 adj : adjust mode, enables blinking
//                 sel : blink target, 1 = seconds pair, 0 = minutes pair
//                 seg : segment cathodes {g,f,e,d,c,b,a}, active-low
//                 dp  : decimal point, active-low
//                 an  : digit anodes, active-low, an[0] = sec_one
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_display_if;
    logic [3:0] sec_one;
    logic [3:0] sec_ten;
    logic [3:0] min_one;
    logic [3:0] min_ten;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output sec_one, sec_ten, min_one, min_ten, adj, sel,
        input  seg, dp, an
    );

    modport slave (
        input  sec_one, sec_ten, min_one, min_ten, adj, sel,
        output seg, dp, an
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_display
// Description : 4-digit common-anode time-multiplexed seven-segment driver.
//               Each digit is lit for REFRESH_DIV cycles; the four BCD inputs
//               are snapshotted once per scan frame so a frame never tears.
//               In adjust mode the selected digit pair blinks with a
//               half-period of BLINK_DIV cycles. All outputs are registered.
//               Ports:
//                 clk : system clock
//                 rst : synchronous active-high reset
//                 bus : seven_seg_display_if.slave (digits, adj, sel in;
//                       seg, dp, an out)
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_display_if.slave   bus
);

    localparam int c_refresh_w = $clog2(REFRESH_DIV);
    localparam int c_blink_w   = $clog2(BLINK_DIV);
    localparam logic [c_refresh_w-1:0] c_refresh_last = c_refresh_w'(REFRESH_DIV - 1);
    localparam logic [c_blink_w-1:0]   c_blink_last   = c_blink_w'(BLINK_DIV - 1);
    localparam logic [6:0]             c_seg_blank    = 7'h7F;

    logic [c_refresh_w-1:0] r_refresh_cnt;
    logic [c_blink_w-1:0]   r_blink_cnt;
    logic                   r_blink_vis;
    logic [1:0]             r_idx;
    logic [3:0]             r_snap [4];
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic [3:0]             r_an;

    logic                   w_refresh_tc;
    logic                   w_blink_tc;
    logic                   w_blank;
    logic [3:0]             w_digit;

    // Active-low decode; non-BCD codes are shown blank.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = c_seg_blank;
        endcase
        return s;
    endfunction

    assign w_refresh_tc = (r_refresh_cnt == c_refresh_last);
    assign w_blink_tc   = (r_blink_cnt == c_blink_last);
    assign w_digit      = r_snap[r_idx];

    // sel=1 targets the seconds pair (idx 0,1), sel=0 the minutes pair (idx 2,3).
    // adj/sel are used live so mode changes take effect on the next output update.
    assign w_blank = bus.adj && !r_blink_vis && (bus.sel ? !r_idx[1] : r_idx[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_blink_cnt   <= '0;
            r_blink_vis   <= 1'b1;
            r_idx         <= 2'd0;
            r_snap[0]     <= 4'd0;
            r_snap[1]     <= 4'd0;
            r_snap[2]     <= 4'd0;
            r_snap[3]     <= 4'd0;
            r_an          <= 4'b1111;
            r_seg         <= c_seg_blank;
            r_dp          <= 1'b1;
        end else begin
            if (w_refresh_tc) begin
                r_refresh_cnt <= '0;
                r_idx         <= r_idx + 2'd1;
                // Frame boundary: new digits are first shown in the idx 0 slot.
                if (r_idx == 2'd3) begin
                    r_snap[0] <= bus.sec_one;
                    r_snap[1] <= bus.sec_ten;
                    r_snap[2] <= bus.min_one;
                    r_snap[3] <= bus.min_ten;
                end
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end

            if (w_blink_tc) begin
                r_blink_cnt <= '0;
                r_blink_vis <= ~r_blink_vis;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank ? c_seg_blank : decode(w_digit);
            // Separator after the minutes digits; suppressed while that digit blinks off.
            r_dp  <= !((r_idx == 2'd2) && !w_blank);
        end
    end

    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
    assign bus.an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_display
// Description : Self-checking bench for seven_seg_display with REFRESH_DIV=4,
//               BLINK_DIV=16. Expected outputs come from an arithmetic model
//               indexed by the number of clock edges since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_display;

    localparam int c_r = 4;
    localparam int c_b = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seven_seg_display_if bus ();

    seven_seg_display #(
        .REFRESH_DIV (c_r),
        .BLINK_DIV   (c_b)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         n        = 0;
    logic [3:0] m_snap [4];
    logic [6:0] seg_tab [16];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic set_digits(input logic [3:0] mt, input logic [3:0] mo,
                              input logic [3:0] st, input logic [3:0] so);
        bus.min_ten = mt;
        bus.min_one = mo;
        bus.sec_ten = st;
        bus.sec_one = so;
    endtask

    task automatic set_random_digits();
        bus.min_ten = 4'($urandom);
        bus.min_one = 4'($urandom);
        bus.sec_ten = 4'($urandom);
        bus.sec_one = 4'($urandom);
    endtask

    // One clock edge: predict outputs from the edge count since reset,
    // then compare one time unit after the edge.
    task automatic tick();
        int         idx;
        logic       blank;
        logic [3:0] dig [4];
        @(posedge clk);
        dig[0] = bus.sec_one;
        dig[1] = bus.sec_ten;
        dig[2] = bus.min_one;
        dig[3] = bus.min_ten;
        if (rst) begin
            n       = 0;
            for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            idx     = (n / c_r) % 4;
            blank   = bus.adj && (((n / c_b) % 2) == 1) &&
                      (bus.sel ? (idx < 2) : (idx >= 2));
            exp_an  = 4'hF;
            exp_an[idx] = 1'b0;
            exp_seg = blank ? 7'h7F : seg_tab[m_snap[idx]];
            exp_dp  = !((idx == 2) && !blank);
            if (((n + 1) % (4 * c_r)) == 0) begin
                for (int k = 0; k < 4; k++) m_snap[k] = dig[k];
            end
            n++;
        end
        #1;
        check("an",  {3'b000, bus.an}, {3'b000, exp_an});
        check("seg", bus.seg, exp_seg);
        check("dp",  {6'd0, bus.dp}, {6'd0, exp_dp});
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
        rst     = 1'b1;
        bus.adj = 1'b0;
        bus.sel = 1'b0;
        set_random_digits();

        // Reset held with arbitrary inputs
        for (int k = 0; k < 3; k++) begin
            tick();
            set_random_digits();
        end
        check("rst_an",  {3'b000, bus.an}, 7'h0F);
        check("rst_seg", bus.seg, 7'h7F);

        // Release: first slot shows a zero
        rst = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        check("rel_an",  {3'b000, bus.an}, 7'h0E);
        check("rel_seg", bus.seg, 7'h40);

        // Two frames of plain scan
        run(31);
        check("f2_last_seg", bus.seg, 7'h79);

        // Decode sweep on sec_one, one value per frame
        for (int v = 0; v < 16; v++) begin
            bus.sec_one = 4'(v);
            run(16);
        end

        // Inputs changed mid-frame stay invisible until the frame boundary
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        while ((n % 16) != 0) tick();
        run(16);
        while ((n % 16) != 5) tick();
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        run(27);

        // Blink on seconds, then minutes, then off
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.adj = 1'b1;
        bus.sel = 1'b1;
        run(48);
        bus.sel = 1'b0;
        run(48);
        bus.adj = 1'b0;
        run(20);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) set_random_digits();
            if ($urandom_range(0, 15) == 0) bus.adj = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.sel = 1'($urandom);
            tick();
        end
        rst     = 1'b0;
        bus.adj = 1'b0;

        // Reset in the middle of a frame
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        while ((n % 16) != 0) tick();
        run(16);
        while (((n / c_r) % 4) != 2) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_an",  {3'b000, bus.an}, 7'h0F);
        check("mid_rst_seg", bus.seg, 7'h7F);
        rst = 1'b0;
        tick();
        check("mid_rel_an",  {3'b000, bus.an}, 7'h0E);
        check("mid_rel_seg", bus.seg, 7'h40);
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
